// File: rtl/button_debounce.sv
// Two-channel push-button front end: synchronize, debounce, then turn each
// debounced press into a press pulse plus timed auto-repeat pulses.
module button_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic control_up,
    input  logic control_down,
    output logic button_up,
    output logic button_down,
    output logic held_up,
    output logic held_down,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DELAY,
        REPEAT
    } state_t;

    // Channel 0 is "up", channel 1 is "down".
    logic [1:0]        raw;
    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        level;
    logic [1:0]        level_next;
    logic [1:0]        pulse;
    logic [1:0][15:0]  count;
    logic [1:0][23:0]  timer;
    state_t [1:0]      state;
    logic              conflict_next;
    logic              hold;

    assign raw = {control_down, control_up};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the async reset clears all state independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The debounced level flips on the edge its counter completes the run, so the
    // FSM sees the new level in the same edge and the press pulse lines up with it.
    always_comb begin
        level_next = level;
        for (int ch = 0; ch < 2; ch++) begin
            if ((sync2[ch] != level[ch]) && (count[ch] == DEBOUNCE_CYCLES - 16'd1)) begin
                level_next[ch] = ~level[ch];
            end
        end
    end

    // Hold covers the edge conflict starts and the edge it ends, so the surviving
    // channel restarts its delay from zero once conflict drops.
    assign conflict_next = level_next[0] & level_next[1];
    assign hold          = conflict | conflict_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level    <= '0;
            pulse    <= '0;
            count    <= '0;
            timer    <= '0;
            state[0] <= IDLE;
            state[1] <= IDLE;
        end else begin
            level <= level_next;
            for (int ch = 0; ch < 2; ch++) begin
                if ((sync2[ch] == level[ch]) || (level_next[ch] != level[ch])) begin
                    count[ch] <= '0;
                end else begin
                    count[ch] <= count[ch] + 16'd1;
                end

                pulse[ch] <= 1'b0;
                if (!level_next[ch]) begin
                    state[ch] <= IDLE;
                    timer[ch] <= '0;
                end else if (hold) begin
                    state[ch] <= WAIT_DELAY;
                    timer[ch] <= '0;
                end else begin
                    case (state[ch])
                        IDLE: begin
                            pulse[ch] <= 1'b1;
                            state[ch] <= WAIT_DELAY;
                            timer[ch] <= '0;
                        end
                        WAIT_DELAY: begin
                            if (REPEAT_DELAY != 24'd0) begin
                                if (timer[ch] == REPEAT_DELAY - 24'd1) begin
                                    pulse[ch] <= 1'b1;
                                    state[ch] <= REPEAT;
                                    timer[ch] <= '0;
                                end else if (timer[ch] != '1) begin
                                    timer[ch] <= timer[ch] + 24'd1;
                                end
                            end
                        end
                        REPEAT: begin
                            if (timer[ch] >= REPEAT_PERIOD - 24'd1) begin
                                pulse[ch] <= 1'b1;
                                timer[ch] <= '0;
                            end else if (timer[ch] != '1) begin
                                timer[ch] <= timer[ch] + 24'd1;
                            end
                        end
                        default: begin
                            state[ch] <= IDLE;
                            timer[ch] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign button_up   = pulse[0];
    assign button_down = pulse[1];
    assign held_up     = level[0];
    assign held_down   = level[1];
    assign conflict    = level[0] & level[1];

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios with literal pulse timings plus
// randomized button traffic compared every cycle against a timing-rule model.
module tb_button_debounce;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic control_up = 1'b0;
    logic control_down = 1'b0;
    logic button_up, button_down, held_up, held_down, conflict;

    button_debounce #(
        .DEBOUNCE_CYCLES(16'd4),
        .REPEAT_DELAY   (24'd10),
        .REPEAT_PERIOD  (24'd5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .control_up  (control_up),
        .control_down(control_down),
        .button_up   (button_up),
        .button_down (button_down),
        .held_up     (held_up),
        .held_down   (held_down),
        .conflict    (conflict)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;
    int base = 0;
    int up_q[$];
    int down_q[$];
    bit up_held_seen = 1'b0;
    int exp3[5] = '{5, 15, 20, 25, 30};

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: level flips once the synchronized sample has disagreed for D straight
    // cycles; pulses follow from time held since the press (or since conflict ended).
    bit m_s1[2], m_s2[2], m_db[2], m_pulse[2];
    bit m_prev_conf;
    int m_cyc;
    int m_last_eq[2];
    int m_t[2];

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 0; m_s2[ch] = 0; m_db[ch] = 0; m_pulse[ch] = 0;
            m_last_eq[ch] = 0; m_t[ch] = 0;
        end
        m_prev_conf = 0;
        m_cyc = 0;
    endtask

    task automatic model_step();
        bit in_lvl[2];
        bit prev_db[2];
        bit conf;
        bit rose;
        in_lvl[0] = control_up;
        in_lvl[1] = control_down;
        m_cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            prev_db[ch] = m_db[ch];
            if (m_s2[ch] == m_db[ch]) m_last_eq[ch] = m_cyc;
            else if (m_cyc - m_last_eq[ch] >= D) begin
                m_db[ch] = !m_db[ch];
                m_last_eq[ch] = m_cyc;
            end
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = in_lvl[ch];
        end
        conf = m_db[0] && m_db[1];
        for (int ch = 0; ch < 2; ch++) begin
            rose = m_db[ch] && !prev_db[ch];
            if (!m_db[ch] || conf || rose || m_prev_conf) m_t[ch] = 0;
            else m_t[ch]++;
            m_pulse[ch] = m_db[ch] && !conf &&
                          (rose || (RD > 0 && m_t[ch] >= RD && ((m_t[ch] - RD) % RP) == 0));
        end
        m_prev_conf = conf;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        check("held_up", held_up, m_db[0]);
        check("held_down", held_down, m_db[1]);
        check("conflict", conflict, m_db[0] && m_db[1]);
        check("button_up", button_up, m_pulse[0]);
        check("button_down", button_down, m_pulse[1]);
        if (button_up && button_down) check("pulse_exclusive", 1, 0);
    end

    initial forever begin
        @(negedge clk);
        if (button_up) up_q.push_back(edge_cnt - base - 1);
        if (button_down) down_q.push_back(edge_cnt - base - 1);
        if (held_up) up_held_seen = 1'b1;
    end

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic start_test();
        up_q.delete();
        down_q.delete();
        up_held_seen = 1'b0;
        base = edge_cnt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_button_up", button_up, 0);
        check("reset_held_up", held_up, 0);
        check("reset_conflict", conflict, 0);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single press held 8 cycles.
        start_test();
        control_up = 1'b1;
        repeat (8) @(negedge clk);
        check("t1_held_up", held_up, 1);
        control_up = 1'b0;
        repeat (10) @(negedge clk);
        check("t1_pulse_count", up_q.size(), 1);
        check("t1_pulse_edge", q_at(up_q, 0), 5);
        check("t1_released", held_up, 0);

        // Bouncing input: 3 high, 1 low for 40 cycles.
        start_test();
        for (int i = 0; i < 40; i++) begin
            control_up = (i % 4) < 3;
            @(negedge clk);
        end
        control_up = 1'b0;
        repeat (8) @(negedge clk);
        check("t2_pulse_count", up_q.size(), 0);
        check("t2_held_seen", up_held_seen, 0);

        // Down held 30 cycles: press plus auto-repeat, silent release.
        start_test();
        control_down = 1'b1;
        repeat (30) @(negedge clk);
        control_down = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_held_before_fall", held_down, 1);
        @(negedge clk);
        check("t3_held_after_6", held_down, 0);
        repeat (8) @(negedge clk);
        check("t3_pulse_count", down_q.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("t3_pulse%0d_edge", i), q_at(down_q, i), exp3[i]);

        // Simultaneous press -> conflict; drop down -> up resumes with full delay.
        start_test();
        control_up = 1'b1;
        control_down = 1'b1;
        repeat (8) @(negedge clk);
        check("t4_conflict_on", conflict, 1);
        repeat (4) @(negedge clk);
        control_down = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_conflict_still", conflict, 1);
        @(negedge clk);
        check("t4_conflict_off", conflict, 0);
        repeat (12) @(negedge clk);
        check("t4_up_count", up_q.size(), 1);
        check("t4_up_edge", q_at(up_q, 0), 27);
        check("t4_down_count", down_q.size(), 0);
        control_up = 1'b0;
        repeat (10) @(negedge clk);

        // Reset two cycles before the press pulse, button held through release.
        start_test();
        control_up = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_held_up", held_up, 0);
        check("t5_rst_button_up", button_up, 0);
        check("t5_rst_conflict", conflict, 0);
        repeat (2) @(negedge clk);
        check("t5_no_pulse_aborted", up_q.size(), 0);
        #2 rst = 1'b0;
        start_test();
        repeat (10) @(negedge clk);
        check("t5_pulse_count", up_q.size(), 1);
        check("t5_pulse_edge", q_at(up_q, 0), 5);
        control_up = 1'b0;
        repeat (10) @(negedge clk);

        // Reset mid-repeat clears the debounced level immediately.
        start_test();
        control_down = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_held_before", held_down, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_held_down", held_down, 0);
        check("t6_rst_button_down", button_down, 0);
        control_down = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized traffic in slow and fast blocks, occasional reset.
        for (int blk = 0; blk < 16; blk++) begin
            int rate;
            rate = (blk % 3 == 2) ? 4 : 30;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, rate) == 0) control_up = ~control_up;
                if ($urandom_range(0, rate) == 0) control_down = ~control_down;
                if ($urandom_range(0, 599) == 0) begin
                    #2 rst = 1'b1;
                    @(negedge clk);
                    #2 rst = 1'b0;
                end
                @(negedge clk);
            end
        end
        control_up = 1'b0;
        control_down = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
